// File: rtl/uart_tx_framer.sv
// rtl/uart_tx_framer.sv - frames NWORDS 64-bit cipher words plus a 128-bit tag into UART byte loads
module uart_tx_framer #(
  parameter int NWORDS = 23,
  parameter int GUARD  = 4
) (
  input  logic         clock_i,
  input  logic         resetb_i,
  input  logic         start_i,
  input  logic [63:0]  word_i,
  input  logic         word_valid_i,
  output logic         word_ready_o,
  input  logic [127:0] tag_i,
  input  logic         tag_valid_i,
  input  logic         TxBusy_i,
  output logic [7:0]   TxByte_o,
  output logic         Load_o,
  output logic         busy_o,
  output logic         done_o
);

  localparam int GW = (GUARD > 1) ? $clog2(GUARD) : 1;

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, WAIT_HI, WAIT_LO, TAG_WAIT, DONE} state_t;

  state_t         state_q, state_d;
  logic [63:0]    word_q;
  logic [127:0]   tag_q;
  logic           tag_latched;
  logic           tag_phase;
  logic [2:0]     byte_cnt;
  logic [4:0]     word_cnt;
  logic [3:0]     tag_cnt;
  logic [GW-1:0]  guard_cnt;
  logic [7:0]     byte_q;
  logic [7:0]     cur_byte;
  logic           start_frame, take_word, load_fire, byte_adv, word_adv, tag_go, tag_adv;

  // Byte 0 is the most significant byte of the word or tag.
  assign cur_byte = tag_phase ? 8'(tag_q >> {~tag_cnt, 3'b000})
                              : 8'(word_q >> {~byte_cnt, 3'b000});

  assign start_frame  = (state_q == IDLE) && start_i;
  assign word_ready_o = (state_q == FETCH);
  assign busy_o       = (state_q != IDLE);
  assign done_o       = (state_q == DONE);
  assign Load_o       = load_fire;
  assign TxByte_o     = load_fire ? cur_byte : byte_q;

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    take_word = 1'b0;
    load_fire = 1'b0;
    byte_adv  = 1'b0;
    word_adv  = 1'b0;
    tag_go    = 1'b0;
    tag_adv   = 1'b0;
    case (state_q)
      IDLE:    if (start_i) state_d = FETCH;
      FETCH:   if (word_valid_i) begin take_word = 1'b1; state_d = LOAD; end
      LOAD:    if (!TxBusy_i) begin load_fire = 1'b1; state_d = WAIT_HI; end
      WAIT_HI: if (TxBusy_i || guard_cnt == GW'(GUARD - 1)) state_d = WAIT_LO;
      WAIT_LO: if (!TxBusy_i) begin
        if (tag_phase) begin
          if (tag_cnt != 4'd15) begin tag_adv = 1'b1; state_d = LOAD; end
          else state_d = DONE;
        end else if (byte_cnt != 3'd7) begin
          byte_adv = 1'b1; state_d = LOAD;
        end else if (word_cnt != 5'(NWORDS - 1)) begin
          word_adv = 1'b1; state_d = FETCH;
        end else begin
          state_d = TAG_WAIT;
        end
      end
      TAG_WAIT: if (tag_latched || tag_valid_i) begin tag_go = 1'b1; state_d = LOAD; end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      word_q      <= '0;
      tag_q       <= '0;
      tag_latched <= 1'b0;
      tag_phase   <= 1'b0;
      byte_cnt    <= '0;
      word_cnt    <= '0;
      tag_cnt     <= '0;
      guard_cnt   <= '0;
      byte_q      <= '0;
    end else begin
      // The first tag_valid_i seen since start_i wins; later pulses are ignored.
      if (start_frame) begin
        tag_latched <= tag_valid_i;
        if (tag_valid_i) tag_q <= tag_i;
        tag_phase <= 1'b0;
        byte_cnt  <= '0;
        word_cnt  <= '0;
        tag_cnt   <= '0;
      end else if (state_q != IDLE && !tag_latched && tag_valid_i) begin
        tag_latched <= 1'b1;
        tag_q       <= tag_i;
      end
      if (take_word) begin
        word_q   <= word_i;
        byte_cnt <= '0;
      end
      if (byte_adv) byte_cnt <= byte_cnt + 3'd1;
      if (word_adv) word_cnt <= word_cnt + 5'd1;
      if (tag_go) begin
        tag_phase <= 1'b1;
        tag_cnt   <= '0;
      end
      if (tag_adv) tag_cnt <= tag_cnt + 4'd1;
      if (load_fire) begin
        byte_q    <= cur_byte;
        guard_cnt <= '0;
      end else if (state_q == WAIT_HI && guard_cnt != GW'(GUARD - 1)) begin
        guard_cnt <= guard_cnt + GW'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// tb/tb_uart_tx_framer.sv - scoreboard bench for uart_tx_framer with NWORDS=2
module tb_uart_tx_framer;

  logic         clock_i = 1'b0;
  logic         resetb_i = 1'b0;
  logic         start_i = 1'b0;
  logic [63:0]  word_i = '0;
  logic         word_valid_i = 1'b0;
  logic         word_ready_o;
  logic [127:0] tag_i = '0;
  logic         tag_valid_i = 1'b0;
  logic         TxBusy_i;
  logic [7:0]   TxByte_o;
  logic         Load_o;
  logic         busy_o;
  logic         done_o;

  logic         model_busy = 1'b0;
  logic         hold_busy = 1'b0;
  assign TxBusy_i = model_busy | hold_busy;

  uart_tx_framer #(.NWORDS(2), .GUARD(4)) dut (
    .clock_i(clock_i), .resetb_i(resetb_i), .start_i(start_i),
    .word_i(word_i), .word_valid_i(word_valid_i), .word_ready_o(word_ready_o),
    .tag_i(tag_i), .tag_valid_i(tag_valid_i), .TxBusy_i(TxBusy_i),
    .TxByte_o(TxByte_o), .Load_o(Load_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clock_i = ~clock_i;

  int n_checks = 0;
  int n_fail = 0;
  int n_loads = 0;
  int n_done = 0;
  logic [7:0]  exp_q[$];
  logic [63:0] w_q[$];

  localparam logic [63:0]  W0 = 64'h0011223344556677;
  localparam logic [63:0]  W1 = 64'h8899AABBCCDDEEFF;
  localparam logic [127:0] T0 = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] T1 = 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // UART model, word source and scoreboard consumer share one loop.
  initial begin
    int busy_cnt = 0;
    logic ld, acc;
    forever begin
      @(negedge clock_i);
      ld  = Load_o;
      acc = word_ready_o && word_valid_i;
      if (ld) begin
        n_loads++;
        if (exp_q.size() == 0) check("unexpected_load", 64'(TxByte_o), 64'hDEAD);
        else check("tx_byte", 64'(TxByte_o), 64'(exp_q.pop_front()));
      end
      if (done_o) n_done++;
      @(posedge clock_i);
      #1;
      if (acc && w_q.size() > 0) void'(w_q.pop_front());
      word_valid_i = (w_q.size() > 0);
      word_i       = (w_q.size() > 0) ? w_q[0] : 64'h0;
      if (ld) busy_cnt = 10;
      else if (busy_cnt > 0) busy_cnt--;
      model_busy = (busy_cnt > 0);
    end
  end

  task automatic push_frame(input logic [127:0] tag);
    logic [63:0]  w;
    logic [127:0] t;
    w_q.push_back(W0);
    w_q.push_back(W1);
    for (int k = 0; k < 2; k++) begin
      w = (k == 0) ? W0 : W1;
      for (int b = 0; b < 8; b++) exp_q.push_back(w[63-8*b -: 8]);
    end
    t = tag;
    for (int b = 0; b < 16; b++) exp_q.push_back(t[127-8*b -: 8]);
  endtask

  task automatic pulse_start(input logic with_tag, input logic [127:0] tag);
    @(posedge clock_i); #1;
    start_i = 1'b1;
    tag_valid_i = with_tag;
    tag_i = tag;
    @(posedge clock_i); #1;
    start_i = 1'b0;
    tag_valid_i = 1'b0;
  endtask

  task automatic pulse_tag(input logic [127:0] tag);
    @(posedge clock_i); #1;
    tag_valid_i = 1'b1;
    tag_i = tag;
    @(posedge clock_i); #1;
    tag_valid_i = 1'b0;
  endtask

  task automatic wait_done(input string name, input int l0, input int d0);
    int cyc = 0;
    while (n_done == d0 && cyc < 3000) begin @(posedge clock_i); cyc++; end
    check({name, "_done_timeout"}, 64'(cyc < 3000), 64'd1);
    repeat (3) @(posedge clock_i);
    check({name, "_load_count"}, 64'(n_loads - l0), 64'd32);
    check({name, "_done_count"}, 64'(n_done - d0), 64'd1);
    check({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    repeat (12) @(posedge clock_i);
  endtask

  task automatic wait_loads(input string name, input int target);
    int cyc = 0;
    while (n_loads < target && cyc < 1000) begin @(posedge clock_i); cyc++; end
    check({name, "_load_timeout"}, 64'(cyc < 1000), 64'd1);
  endtask

  initial begin
    int l0, d0;
    // Reset state
    repeat (3) @(posedge clock_i);
    #1;
    check("rst_load", 64'(Load_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_ready", 64'(word_ready_o), 64'd0);
    check("rst_byte", 64'(TxByte_o), 64'd0);
    resetb_i = 1'b1;
    repeat (2) @(posedge clock_i);

    // Basic frame, tag presented with start
    l0 = n_loads; d0 = n_done;
    push_frame(T0);
    pulse_start(1'b1, T0);
    wait_done("basic", l0, d0);

    // UART busy at the first load
    l0 = n_loads; d0 = n_done;
    push_frame(T0);
    hold_busy = 1'b1;
    pulse_start(1'b1, T0);
    repeat (50) @(posedge clock_i);
    check("held_no_load", 64'(n_loads - l0), 64'd0);
    check("held_busy_o", 64'(busy_o), 64'd1);
    #1 hold_busy = 1'b0;
    @(negedge clock_i);
    check("release_load", 64'(Load_o), 64'd1);
    wait_done("held", l0, d0);

    // Tag a cycle late, second tag_valid_i ignored
    l0 = n_loads; d0 = n_done;
    push_frame(T1);
    pulse_start(1'b0, '0);
    tag_valid_i = 1'b1; tag_i = T1;
    @(posedge clock_i); #1;
    tag_valid_i = 1'b0;
    repeat (5) @(posedge clock_i);
    pulse_tag({128{1'b1}});
    wait_done("first_tag", l0, d0);

    // Tag withheld past the last word byte
    l0 = n_loads; d0 = n_done;
    push_frame(T0);
    pulse_start(1'b0, '0);
    wait_loads("withheld", l0 + 16);
    repeat (20) @(posedge clock_i);
    repeat (100) @(posedge clock_i);
    check("tagwait_no_load", 64'(n_loads - l0), 64'd16);
    check("tagwait_busy", 64'(busy_o), 64'd1);
    pulse_tag(T0);
    wait_done("withheld", l0, d0);

    // Reset mid-frame after the 5th byte
    l0 = n_loads; d0 = n_done;
    push_frame(T0);
    pulse_start(1'b1, T0);
    wait_loads("midreset", l0 + 5);
    @(posedge clock_i); #1;
    resetb_i = 1'b0;
    #1;
    check("midrst_load", 64'(Load_o), 64'd0);
    check("midrst_busy", 64'(busy_o), 64'd0);
    check("midrst_byte", 64'(TxByte_o), 64'd0);
    exp_q.delete();
    w_q.delete();
    @(posedge clock_i); #1;
    resetb_i = 1'b1;
    repeat (20) @(posedge clock_i);
    check("midrst_no_load", 64'(n_loads - l0), 64'd5);
    check("midrst_no_done", 64'(n_done - d0), 64'd0);
    l0 = n_loads; d0 = n_done;
    push_frame(T0);
    pulse_start(1'b1, T0);
    wait_done("after_reset", l0, d0);

    // start_i while a byte is in flight
    l0 = n_loads; d0 = n_done;
    push_frame(T1);
    pulse_start(1'b1, T1);
    wait_loads("restart", l0 + 3);
    repeat (3) @(posedge clock_i);
    check("restart_in_flight", 64'(busy_o), 64'd1);
    pulse_start(1'b1, T0);
    wait_done("restart", l0, d0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_framer.md
UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 The block SHALL have parameter NWORDS, default 23, giving the number of 64-bit cipher words per frame (1..31).
REQ-002 The block SHALL have parameter GUARD, default 4, giving the cycles to wait for TxBusy_i to rise after a load.
REQ-003 clock_i  in  1  single system clock; all state updates on its rising edge.
REQ-004 resetb_i  in  1  asynchronous, active-low reset.
REQ-005 start_i  in  1  one-cycle request to begin a frame.
REQ-006 word_i  in  64  cipher word, transmitted MSB byte first.
REQ-007 word_valid_i  in  1  word_i is valid.
REQ-008 word_ready_o  out  1  word_i is accepted this cycle when word_valid_i is also high.
REQ-009 tag_i  in  128  authentication tag.
REQ-010 tag_valid_i  in  1  tag_i is valid; sampled as described in REQ-017.
REQ-011 TxBusy_i  in  1  UART transmitter busy.
REQ-012 TxByte_o  out  8  byte presented to the UART.
REQ-013 Load_o  out  1  one-cycle load strobe to the UART.
REQ-014 busy_o  out  1  a frame is in progress.
REQ-015 done_o  out  1  one-cycle pulse when the last tag byte completes.

Function
REQ-016 States: IDLE, FETCH, LOAD, WAIT_HI, WAIT_LO, TAG_WAIT, DONE.
- IDLE to FETCH on start_i.
- start_i SHALL be ignored in all states other than IDLE.
REQ-017 Tag capture:
- From the start_i cycle until the tag is latched, the first cycle with tag_valid_i high SHALL latch tag_i into a 128-bit register.
- Later tag_valid_i pulses within the same frame SHALL be ignored.
REQ-018 In FETCH, word_ready_o SHALL be high.
- When word_valid_i is also high, word_i is latched, byte_cnt is cleared to 0, and the state moves to LOAD.
- Otherwise the state stays in FETCH with no timeout.
REQ-019 In LOAD, when TxBusy_i is low:
- Load_o SHALL pulse for exactly one cycle.
- TxByte_o SHALL hold the current byte: for words, word[63-8*byte_cnt -: 8]; for the tag, tag[127-8*tag_cnt -: 8].
- The state moves to WAIT_HI.
- While TxBusy_i is high, LOAD SHALL wait without pulsing Load_o.
REQ-020 WAIT_HI SHALL move to WAIT_LO on TxBusy_i high, or after GUARD cycles with TxBusy_i low, whichever comes first.
REQ-021 WAIT_LO SHALL wait for TxBusy_i low, then advance:
- next word byte to LOAD while byte_cnt < 7;
- after the 8th byte, to FETCH while word_cnt < NWORDS-1;
- after the last word byte, to TAG_WAIT.
REQ-022 Counter widths: byte_cnt 3 bits, word_cnt 5 bits, tag_cnt 4 bits.
- Each counter increments only on byte completion.
- No counter SHALL wrap within a frame.
REQ-023 TAG_WAIT SHALL go to LOAD (tag phase, tag_cnt=0) once the tag is latched, including when tag_valid_i arrives in that same cycle; otherwise it waits indefinitely.
REQ-024 After the 16th tag byte completes in WAIT_LO, the state SHALL move to DONE.
REQ-025 DONE SHALL assert done_o for one cycle and return to IDLE.
REQ-026 busy_o SHALL be high in every state except IDLE.
REQ-027 TxByte_o SHALL hold its last value between loads.
REQ-028 A frame SHALL be exactly 8*NWORDS+16 Load_o pulses.

Reset
REQ-029 When resetb_i is low, the block SHALL asynchronously enter IDLE and set:
- TxByte_o=0x00; Load_o, word_ready_o, busy_o and done_o = 0;
- all counters = 0;
- the tag-latched flag and the data registers cleared.
REQ-030 Reset mid-frame SHALL abandon the frame with no further Load_o pulses, and no done_o pulse until a new start_i.

Verification
REQ-031 NWORDS=2, words 0x0011223344556677 and 0x8899AABBCCDDEEFF, tag 0x000102...0F, UART model busy 10 cycles per byte -> bytes 00,11,..,77,88,..,FF,00,01,..,0F in order; 32 Load_o pulses; a single done_o pulse.
REQ-032 TxBusy_i held high for 50 cycles at the first LOAD -> no Load_o pulse until TxBusy_i falls, then byte 0x00 is loaded within 1 cycle.
REQ-033 Tag presented 1 cycle after start_i, then tag_valid_i pulsed again with 0xFF..FF -> the transmitted tag equals the first value.
REQ-034 Tag withheld until 100 cycles after the last word byte -> the block holds in TAG_WAIT with busy_o=1 and no Load_o, then sends the 16 tag bytes.
REQ-035 resetb_i low for 1 cycle after the 5th byte -> Load_o=0, busy_o=0, TxByte_o=0x00; a new start_i then sends a complete frame from word 0 byte 0.
REQ-036 start_i pulsed during WAIT_LO -> no effect on byte order or count.
